// File: rtl/board_eliminator.sv
// board_eliminator: owns the 8x8 Pop Star board. Fills it from an LFSR,
// flood-fills the region under the cursor, clears it, applies gravity and
// left column compaction, scores the move and detects game over.

// One column of the gravity step: the lowest hole with a star above it
// closes by dropping everything above it one row.
module board_fall_col (
  input  logic [7:0][2:0] col,
  output logic [7:0][2:0] col_nxt,
  output logic            moved
);
  logic       above;
  logic [2:0] e;

  // locate the hole, then build the shifted column
  always_comb begin
    above = 1'b0;
    moved = 1'b0;
    e     = '0;
    for (int r = 0; r < 8; r++) begin
      if (col[r] == 3'd0 && above) begin
        moved = 1'b1;
        e     = 3'(r);
      end
      if (col[r] != 3'd0) above = 1'b1;
    end
    col_nxt = col;
    if (moved) begin
      col_nxt[0] = 3'd0;
      for (int r = 1; r < 8; r++)
        if (3'(r) <= e) col_nxt[r] = col[r-1];
    end
  end
endmodule

module board_eliminator #(
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          MIN_GROUP = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        new_game,
  input  logic        elim_req,
  input  logic [3:0]  cur_x,
  input  logic [3:0]  cur_y,
  input  logic        ld_en,
  input  logic [2:0]  ld_row,
  input  logic [2:0]  ld_col,
  input  logic [2:0]  ld_color,
  input  logic [2:0]  rd_row,
  input  logic [2:0]  rd_col,
  output logic [2:0]  rd_color,
  output logic        busy,
  output logic [15:0] score,
  output logic [6:0]  last_count,
  output logic        game_over
);
  typedef enum logic [2:0] {
    S_FILL, S_IDLE, S_FLOOD, S_CLEAR, S_FALL, S_SHIFT, S_CHECK, S_DONE
  } state_t;

  state_t               state, state_nxt;
  logic                 busy_nxt;
  logic [7:0][7:0][2:0] board;          // board[row][col]
  logic [63:0]          marks;          // index {row,col}
  logic [5:0]           stack [64];
  logic [6:0]           sp;
  logic [6:0]           count;
  logic [5:0]           fill_idx;
  logic [15:0]          lfsr;

  logic [2:0]           fill_color, ld_val;
  logic                 start_ok, elim_go, ld_go, accept;

  assign rd_color   = board[rd_row][rd_col];
  assign fill_color = (lfsr[2:0] >= 3'd5) ? lfsr[2:0] - 3'd4 : lfsr[2:0] + 3'd1;
  assign ld_val     = (ld_color > 3'd5) ? 3'd0 : ld_color;
  assign accept     = (state == S_IDLE) || (state == S_DONE);
  assign start_ok   = ~cur_x[3] & ~cur_y[3] & (board[cur_x[2:0]][cur_y[2:0]] != 3'd0);
  assign elim_go    = (state == S_IDLE) && elim_req && !new_game && start_ok;
  assign ld_go      = accept && ld_en && !new_game && !elim_go;

  // ---------------- flood: top of stack and its neighbours ----------------
  logic [5:0]      top;
  logic [2:0]      tr, tc, tcol;
  logic [3:0]      nb_rng, nb_ok;
  logic [3:0][5:0] nb_idx, nb_slot;
  logic [2:0]      npush;

  assign top  = stack[sp[5:0] - 6'd1];
  assign tr   = top[5:3];
  assign tc   = top[2:0];
  assign tcol = board[tr][tc];

  // qualify up/down/left/right and pack accepted pushes onto the stack
  always_comb begin
    nb_idx[0] = {tr - 3'd1, tc};
    nb_idx[1] = {tr + 3'd1, tc};
    nb_idx[2] = {tr, tc - 3'd1};
    nb_idx[3] = {tr, tc + 3'd1};
    nb_rng    = {tc != 3'd7, tc != 3'd0, tr != 3'd7, tr != 3'd0};
    nb_ok     = '0;
    nb_slot   = '0;
    npush     = '0;
    for (int k = 0; k < 4; k++) begin
      nb_ok[k]   = nb_rng[k] && (board[nb_idx[k][5:3]][nb_idx[k][2:0]] == tcol)
                   && !marks[nb_idx[k]];
      nb_slot[k] = 6'(sp - 7'd1 + 7'(npush));
      if (nb_ok[k]) npush = npush + 3'd1;
    end
  end

  // ---------------- gravity, one step per column ----------------
  logic [7:0][7:0][2:0] col_in, col_out, fall_board;
  logic [7:0]           col_moved;

  for (genvar c = 0; c < 8; c++) begin : g_col
    for (genvar r = 0; r < 8; r++) begin : g_row
      assign col_in[c][r]     = board[r][c];
      assign fall_board[r][c] = col_out[c][r];
    end
    board_fall_col u_fall (
      .col     (col_in[c]),
      .col_nxt (col_out[c]),
      .moved   (col_moved[c])
    );
  end

  // ---------------- left compaction, one column per step ----------------
  logic [7:0][7:0][2:0] shift_board;
  logic                 shift_found, right_nz;
  logic [2:0]           se;

  // leftmost empty column with stars to its right pulls the rest left
  always_comb begin
    right_nz    = 1'b0;
    shift_found = 1'b0;
    se          = '0;
    for (int c = 7; c >= 0; c--) begin
      if (board[7][c] == 3'd0 && right_nz) begin
        shift_found = 1'b1;
        se          = 3'(c);
      end
      if (board[7][c] != 3'd0) right_nz = 1'b1;
    end
    shift_board = board;
    if (shift_found) begin
      for (int c = 0; c < 7; c++)
        for (int r = 0; r < 8; r++)
          if (3'(c) >= se) shift_board[r][c] = board[r][c+1];
      for (int r = 0; r < 8; r++) shift_board[r][7] = 3'd0;
    end
  end

  // ---------------- any legal move left ----------------
  logic any_pair;

  // a move exists iff two orthogonal neighbours share a colour
  always_comb begin
    any_pair = 1'b0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 7; c++)
        if (board[r][c] != 3'd0 && board[r][c] == board[r][c+1]) any_pair = 1'b1;
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 8; c++)
        if (board[r][c] != 3'd0 && board[r][c] == board[r+1][c]) any_pair = 1'b1;
  end

  // ---------------- score ----------------
  logic [13:0] sq;
  logic [16:0] sum;
  assign sq  = 14'(count) * 14'(count);
  assign sum = 17'(score) + 17'(sq);

  // ---------------- FSM ----------------
  // state register and registered busy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FILL;
      busy  <= 1'b1;
    end else begin
      state <= state_nxt;
      busy  <= busy_nxt;
    end
  end

  // next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      S_FILL:         if (fill_idx == 6'd63) state_nxt = S_CHECK;
      S_IDLE, S_DONE: if (new_game) state_nxt = S_FILL;
                      else if (elim_go) state_nxt = S_FLOOD;
      S_FLOOD:        if (sp == 7'd0)
                        state_nxt = (count >= 7'(MIN_GROUP)) ? S_CLEAR : S_IDLE;
      S_CLEAR:        state_nxt = S_FALL;
      S_FALL:         if (!(|col_moved)) state_nxt = S_SHIFT;
      S_SHIFT:        if (!shift_found) state_nxt = S_CHECK;
      S_CHECK:        state_nxt = any_pair ? S_IDLE : S_DONE;
      default:        state_nxt = S_FILL;
    endcase
  end

  // outputs: busy follows the state being entered
  always_comb begin
    busy_nxt = !((state_nxt == S_IDLE) || (state_nxt == S_DONE));
  end

  // free-running board-fill LFSR (Galois, x^16+x^14+x^13+x^11)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr <= SEED;
    else     lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end

  // flood stack storage; contents are don't-care while sp is 0
  always_ff @(posedge clk) begin
    if (elim_go)
      stack[0] <= {cur_x[2:0], cur_y[2:0]};
    else if (state == S_FLOOD && sp != 7'd0)
      for (int k = 0; k < 4; k++)
        if (nb_ok[k]) stack[nb_slot[k]] <= nb_idx[k];
  end

  // board, marks and scoring datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      board      <= '0;
      marks      <= '0;
      sp         <= '0;
      count      <= '0;
      fill_idx   <= '0;
      score      <= '0;
      last_count <= '0;
      game_over  <= 1'b0;
    end else begin
      case (state)
        S_FILL: begin
          board[fill_idx[5:3]][fill_idx[2:0]] <= fill_color;
          fill_idx <= fill_idx + 6'd1;
        end
        S_IDLE, S_DONE: begin
          if (new_game) begin
            score     <= '0;
            game_over <= 1'b0;
            fill_idx  <= '0;
          end else if (elim_go) begin
            marks[{cur_x[2:0], cur_y[2:0]}] <= 1'b1;
            sp    <= 7'd1;
            count <= 7'd1;
          end else if (ld_go) begin
            board[ld_row][ld_col] <= ld_val;
          end
        end
        S_FLOOD: begin
          if (sp != 7'd0) begin
            sp    <= sp - 7'd1 + 7'(npush);
            count <= count + 7'(npush);
            for (int k = 0; k < 4; k++)
              if (nb_ok[k]) marks[nb_idx[k]] <= 1'b1;
          end else if (count < 7'(MIN_GROUP)) begin
            marks      <= '0;
            last_count <= count;
          end
        end
        S_CLEAR: begin
          for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
              if (marks[r*8+c]) board[r][c] <= 3'd0;
          marks      <= '0;
          last_count <= count;
          score      <= sum[16] ? 16'hFFFF : sum[15:0];
        end
        S_FALL:  board <= fall_board;
        S_SHIFT: board <= shift_board;
        S_CHECK: game_over <= !any_pair;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_board_eliminator.sv
// tb_board_eliminator: scenario tasks with a queue scoreboard of expected
// board cells and status values, compared when the engine goes idle.
module tb_board_eliminator;
  logic        clk = 1'b0, rst = 1'b0, new_game = 1'b0, elim_req = 1'b0, ld_en = 1'b0;
  logic [3:0]  cur_x = '0, cur_y = '0;
  logic [2:0]  ld_row = '0, ld_col = '0, ld_color = '0, rd_row = '0, rd_col = '0;
  logic [2:0]  rd_color;
  logic        busy, game_over;
  logic [15:0] score;
  logic [6:0]  last_count;

  int checks = 0, failures = 0;
  int exp_q[$];
  int mdl[8][8];
  int fill_ref[8][8];
  int exp_score = 0;

  board_eliminator dut (
    .clk(clk), .rst(rst), .new_game(new_game), .elim_req(elim_req),
    .cur_x(cur_x), .cur_y(cur_y), .ld_en(ld_en), .ld_row(ld_row), .ld_col(ld_col),
    .ld_color(ld_color), .rd_row(rd_row), .rd_col(rd_col), .rd_color(rd_color),
    .busy(busy), .score(score), .last_count(last_count), .game_over(game_over)
  );

  always #5 clk = ~clk;

  function automatic int chk(int r, int c);
    return ((r + c) % 2 != 0) ? 2 : 1;
  endfunction

  task automatic build_fill_ref();
    logic [15:0] l;
    int v;
    l = 16'hACE1;
    for (int i = 0; i < 64; i++) begin
      v = int'(l[2:0]);
      fill_ref[i/8][i%8] = (v >= 5) ? v - 5 + 1 : v + 1;
      l = {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
    end
  endtask

  task automatic set_checker();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) mdl[r][c] = chk(r, c);
  endtask

  task automatic set_big_region();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) mdl[r][c] = 1;
    mdl[7][6] = 2;
    mdl[7][7] = 2;
  endtask

  task automatic push_board();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) exp_q.push_back(mdl[r][c]);
  endtask

  task automatic load_mdl();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        ld_en = 1'b1; ld_row = 3'(r); ld_col = 3'(c); ld_color = 3'(mdl[r][c]);
      end
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic pulse_elim(input int x, input int y);
    @(negedge clk);
    cur_x = 4'(x); cur_y = 4'(y); elim_req = 1'b1;
    @(negedge clk);
    elim_req = 1'b0;
  endtask

  task automatic pulse_new_game();
    @(negedge clk);
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy) begin
      failures++;
      $display("FAIL %s timeout busy=%0d required=0", tag, busy);
    end
  endtask

  task automatic test_reset();
    int n, e;
    #2 rst = 1'b1;
    #1;
    checks += 4;
    if (busy !== 1'b1)       begin failures++; $display("FAIL rst_busy got=%0d exp=1", busy); end
    if (score !== 16'd0)     begin failures++; $display("FAIL rst_score got=%0d exp=0", score); end
    if (last_count !== 7'd0) begin failures++; $display("FAIL rst_last got=%0d exp=0", last_count); end
    if (game_over !== 1'b0)  begin failures++; $display("FAIL rst_go got=%0d exp=0", game_over); end
    for (int i = 0; i < 64; i++) exp_q.push_back(0);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        rd_row = 3'(r); rd_col = 3'(c); #1;
        e = exp_q.pop_front(); checks++;
        if (rd_color !== 3'(e)) begin
          failures++; $display("FAIL rst_board[%0d][%0d] got=%0d exp=%0d", r, c, rd_color, e);
        end
      end
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 200);
    checks++;
    if (n != 65) begin failures++; $display("FAIL fill_busy_cycles got=%0d exp=65", n); end
    mdl = fill_ref;
    push_board();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        rd_row = 3'(r); rd_col = 3'(c); #1;
        e = exp_q.pop_front(); checks++;
        if (rd_color !== 3'(e)) begin
          failures++; $display("FAIL fill_board[%0d][%0d] got=%0d exp=%0d", r, c, rd_color, e);
        end
      end
    checks += 2;
    if (score !== 16'd0)    begin failures++; $display("FAIL fill_score got=%0d exp=0", score); end
    if (game_over !== 1'b0) begin failures++; $display("FAIL fill_go got=%0d exp=0", game_over); end
    exp_score = 0;
  endtask

  task automatic test_gravity();
    int e;
    set_checker();
    mdl[5][0] = 3; mdl[6][0] = 3; mdl[7][0] = 3;
    load_mdl();
    exp_score += 9;
    exp_q.push_back(exp_score); exp_q.push_back(3); exp_q.push_back(0);
    set_checker();
    for (int r = 0; r < 3; r++) mdl[r][0] = 0;
    for (int r = 3; r < 8; r++) mdl[r][0] = chk(r - 3, 0);
    push_board();
    pulse_elim(7, 0);
    wait_idle("grav_idle", 300);
    e = exp_q.pop_front(); checks++;
    if (score !== 16'(e)) begin failures++; $display("FAIL grav_score got=%0d exp=%0d", score, e); end
    e = exp_q.pop_front(); checks++;
    if (last_count !== 7'(e)) begin failures++; $display("FAIL grav_last got=%0d exp=%0d", last_count, e); end
    e = exp_q.pop_front(); checks++;
    if (game_over !== 1'(e)) begin failures++; $display("FAIL grav_go got=%0d exp=%0d", game_over, e); end
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        rd_row = 3'(r); rd_col = 3'(c); #1;
        e = exp_q.pop_front(); checks++;
        if (rd_color !== 3'(e)) begin
          failures++; $display("FAIL grav_board[%0d][%0d] got=%0d exp=%0d", r, c, rd_color, e);
        end
      end
  endtask

  task automatic test_single();
    int n, e;
    set_checker();
    mdl[3][3] = 3;
    load_mdl();
    exp_q.push_back(exp_score); exp_q.push_back(1);
    push_board();
    @(negedge clk);
    cur_x = 4'd3; cur_y = 4'd3; elim_req = 1'b1;
    @(negedge clk);
    elim_req = 1'b0;
    n = 0;
    while (busy && n < 10) begin n++; @(negedge clk); end
    checks++;
    if (n < 1 || n > 3) begin failures++; $display("FAIL single_busy_cycles got=%0d exp=1..3", n); end
    e = exp_q.pop_front(); checks++;
    if (score !== 16'(e)) begin failures++; $display("FAIL single_score got=%0d exp=%0d", score, e); end
    e = exp_q.pop_front(); checks++;
    if (last_count !== 7'(e)) begin failures++; $display("FAIL single_last got=%0d exp=%0d", last_count, e); end
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        rd_row = 3'(r); rd_col = 3'(c); #1;
        e = exp_q.pop_front(); checks++;
        if (rd_color !== 3'(e)) begin
          failures++; $display("FAIL single_board[%0d][%0d] got=%0d exp=%0d", r, c, rd_color, e);
        end
      end
    // cursor outside the board must be ignored
    pulse_elim(8, 2);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL oor_busy got=%0d exp=0", busy); end
  endtask

  task automatic test_new_game();
    int bad;
    pulse_new_game();
    exp_score = 0;
    wait_idle("ng_idle", 100);
    bad = 0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        rd_row = 3'(r); rd_col = 3'(c); #1;
        if (rd_color < 3'd1 || rd_color > 3'd5) bad++;
      end
    checks += 2;
    if (bad != 0)        begin failures++; $display("FAIL ng_colours bad_cells=%0d exp=0", bad); end
    if (score !== 16'd0) begin failures++; $display("FAIL ng_score got=%0d exp=0", score); end
  endtask

  task automatic test_shift();
    int e;
    set_checker();
    for (int r = 0; r < 8; r++) mdl[r][2] = 4;
    load_mdl();
    exp_score += 64;
    exp_q.push_back(exp_score); exp_q.push_back(8);
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 7; c++) mdl[r][c] = (c < 2) ? chk(r, c) : chk(r, c + 1);
      mdl[r][7] = 0;
    end
    push_board();
    pulse_elim(0, 2);
    wait_idle("shift_idle", 300);
    e = exp_q.pop_front(); checks++;
    if (score !== 16'(e)) begin failures++; $display("FAIL shift_score got=%0d exp=%0d", score, e); end
    e = exp_q.pop_front(); checks++;
    if (last_count !== 7'(e)) begin failures++; $display("FAIL shift_last got=%0d exp=%0d", last_count, e); end
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        rd_row = 3'(r); rd_col = 3'(c); #1;
        e = exp_q.pop_front(); checks++;
        if (rd_color !== 3'(e)) begin
          failures++; $display("FAIL shift_board[%0d][%0d] got=%0d exp=%0d", r, c, rd_color, e);
        end
      end
  endtask

  task automatic test_clear_all();
    int e;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) mdl[r][c] = ((r + c) % 2 != 0) ? 6 : 7;
    mdl[7][0] = 5; mdl[7][1] = 5; mdl[7][5] = 5; mdl[7][6] = 5;
    load_mdl();
    // first pair: remaining pair compacts to columns 0,1
    exp_score += 4;
    exp_q.push_back(exp_score); exp_q.push_back(0);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) mdl[r][c] = 0;
    mdl[7][0] = 5; mdl[7][1] = 5;
    push_board();
    pulse_elim(7, 0);
    wait_idle("pair1_idle", 300);
    e = exp_q.pop_front(); checks++;
    if (score !== 16'(e)) begin failures++; $display("FAIL pair1_score got=%0d exp=%0d", score, e); end
    e = exp_q.pop_front(); checks++;
    if (game_over !== 1'(e)) begin failures++; $display("FAIL pair1_go got=%0d exp=%0d", game_over, e); end
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        rd_row = 3'(r); rd_col = 3'(c); #1;
        e = exp_q.pop_front(); checks++;
        if (rd_color !== 3'(e)) begin
          failures++; $display("FAIL pair1_board[%0d][%0d] got=%0d exp=%0d", r, c, rd_color, e);
        end
      end
    // second pair empties the board
    exp_score += 4;
    exp_q.push_back(exp_score); exp_q.push_back(2); exp_q.push_back(1);
    mdl[7][0] = 0; mdl[7][1] = 0;
    push_board();
    pulse_elim(7, 1);
    wait_idle("pair2_idle", 300);
    e = exp_q.pop_front(); checks++;
    if (score !== 16'(e)) begin failures++; $display("FAIL pair2_score got=%0d exp=%0d", score, e); end
    e = exp_q.pop_front(); checks++;
    if (last_count !== 7'(e)) begin failures++; $display("FAIL pair2_last got=%0d exp=%0d", last_count, e); end
    e = exp_q.pop_front(); checks++;
    if (game_over !== 1'(e)) begin failures++; $display("FAIL pair2_go got=%0d exp=%0d", game_over, e); end
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        rd_row = 3'(r); rd_col = 3'(c); #1;
        e = exp_q.pop_front(); checks++;
        if (rd_color !== 3'(e)) begin
          failures++; $display("FAIL pair2_board[%0d][%0d] got=%0d exp=%0d", r, c, rd_color, e);
        end
      end
    // DONE: load still works, eliminate is ignored
    mdl[7][0] = 5; mdl[7][1] = 5;
    load_mdl();
    exp_q.push_back(exp_score); exp_q.push_back(5);
    pulse_elim(7, 0);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL done_busy got=%0d exp=0", busy); end
    e = exp_q.pop_front(); checks++;
    if (score !== 16'(e)) begin failures++; $display("FAIL done_score got=%0d exp=%0d", score, e); end
    rd_row = 3'd7; rd_col = 3'd0; #1;
    e = exp_q.pop_front(); checks++;
    if (rd_color !== 3'(e)) begin failures++; $display("FAIL done_cell got=%0d exp=%0d", rd_color, e); end
  endtask

  task automatic test_saturation();
    int e;
    pulse_new_game();
    exp_score = 0;
    wait_idle("sat_ng_idle", 100);
    for (int it = 1; it <= 18; it++) begin
      set_big_region();
      load_mdl();
      exp_score = (exp_score + 3844 > 65535) ? 65535 : exp_score + 3844;
      exp_q.push_back(exp_score); exp_q.push_back(62);
      pulse_elim(0, 0);
      wait_idle("sat_idle", 400);
      e = exp_q.pop_front(); checks++;
      if (score !== 16'(e)) begin failures++; $display("FAIL sat_score it=%0d got=%0d exp=%0d", it, score, e); end
      e = exp_q.pop_front(); checks++;
      if (last_count !== 7'(e)) begin failures++; $display("FAIL sat_last it=%0d got=%0d exp=%0d", it, last_count, e); end
    end
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) mdl[r][c] = 0;
    mdl[7][0] = 2; mdl[7][1] = 2;
    push_board();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        rd_row = 3'(r); rd_col = 3'(c); #1;
        e = exp_q.pop_front(); checks++;
        if (rd_color !== 3'(e)) begin
          failures++; $display("FAIL sat_board[%0d][%0d] got=%0d exp=%0d", r, c, rd_color, e);
        end
      end
  endtask

  task automatic test_reset_mid_flood();
    int n, e;
    set_big_region();
    load_mdl();
    pulse_elim(0, 0);
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy_before got=%0d exp=1", busy); end
    rst = 1'b1;
    #1;
    checks += 4;
    if (busy !== 1'b1)       begin failures++; $display("FAIL mid_rst_busy got=%0d exp=1", busy); end
    if (score !== 16'd0)     begin failures++; $display("FAIL mid_rst_score got=%0d exp=0", score); end
    if (last_count !== 7'd0) begin failures++; $display("FAIL mid_rst_last got=%0d exp=0", last_count); end
    if (game_over !== 1'b0)  begin failures++; $display("FAIL mid_rst_go got=%0d exp=0", game_over); end
    for (int i = 0; i < 64; i++) exp_q.push_back(0);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        rd_row = 3'(r); rd_col = 3'(c); #1;
        e = exp_q.pop_front(); checks++;
        if (rd_color !== 3'(e)) begin
          failures++; $display("FAIL mid_rst_board[%0d][%0d] got=%0d exp=%0d", r, c, rd_color, e);
        end
      end
    @(negedge clk);
    rst = 1'b0;
    exp_score = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 200);
    checks++;
    if (n != 65) begin failures++; $display("FAIL refill_busy_cycles got=%0d exp=65", n); end
    mdl = fill_ref;
    push_board();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        rd_row = 3'(r); rd_col = 3'(c); #1;
        e = exp_q.pop_front(); checks++;
        if (rd_color !== 3'(e)) begin
          failures++; $display("FAIL refill_board[%0d][%0d] got=%0d exp=%0d", r, c, rd_color, e);
        end
      end
  endtask

  task automatic test_busy_ignore();
    int e;
    set_big_region();
    load_mdl();
    exp_score += 3844;
    exp_q.push_back(exp_score); exp_q.push_back(62); exp_q.push_back(0);
    pulse_elim(0, 0);
    repeat (3) @(negedge clk);
    new_game = 1'b1; elim_req = 1'b1; cur_x = 4'd7; cur_y = 4'd7;
    @(negedge clk);
    new_game = 1'b0; elim_req = 1'b0;
    wait_idle("ign_idle", 400);
    e = exp_q.pop_front(); checks++;
    if (score !== 16'(e)) begin failures++; $display("FAIL ign_score got=%0d exp=%0d", score, e); end
    e = exp_q.pop_front(); checks++;
    if (last_count !== 7'(e)) begin failures++; $display("FAIL ign_last got=%0d exp=%0d", last_count, e); end
    e = exp_q.pop_front(); checks++;
    if (game_over !== 1'(e)) begin failures++; $display("FAIL ign_go got=%0d exp=%0d", game_over, e); end
    rd_row = 3'd7; rd_col = 3'd0; #1;
    checks++;
    if (rd_color !== 3'd2) begin failures++; $display("FAIL ign_cell got=%0d exp=2", rd_color); end
  endtask

  initial begin
    build_fill_ref();
    test_reset();
    test_gravity();
    test_single();
    test_new_game();
    test_shift();
    test_clear_all();
    test_saturation();
    test_reset_mid_flood();
    test_busy_ignore();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
